// File: rtl/noise_pkg.sv
// Shared types and helpers for the noise injector: FSM states, map-size decode
// and saturation bounds.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [2:0] MAX_SIZE_CODE = 3'd5;

  function automatic logic [2:0] clamp_size(logic [2:0] s);
    return (s > MAX_SIZE_CODE) ? MAX_SIZE_CODE : s;
  endfunction

  function automatic int unsigned map_side(logic [2:0] s);
    return 32'd4 << clamp_size(s);
  endfunction

  function automatic int unsigned map_area(logic [2:0] s);
    return map_side(s) * map_side(s);
  endfunction

  // Signed saturation limits for a w-bit two's complement word.
  function automatic longint sat_hi(int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/noise_injector_mac.sv
// Combinational noise MAC: out = sat(act + round(noise * scale)), with a flag
// raised whenever the saturation clipped the result.
module noise_mac
  import noise_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic [DATA_WIDTH-1:0]  act_i,
  input  logic [DATA_WIDTH-1:0]  noise_i,
  input  logic [SCALE_WIDTH-1:0] scale_i,
  output logic [DATA_WIDTH-1:0]  sum_o,
  output logic                   sat_o
);

  localparam int PW   = DATA_WIDTH + SCALE_WIDTH;
  localparam int SUMW = PW + 1;

  localparam logic signed [PW-1:0]   HALF = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SUMW-1:0] HI   = SUMW'(sat_hi(DATA_WIDTH));
  localparam logic signed [SUMW-1:0] LO   = SUMW'(sat_lo(DATA_WIDTH));

  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_r;
  logic signed [SUMW-1:0] sum;

  always_comb begin
    prod   = $signed(noise_i) * $signed(scale_i);
    prod_r = (prod + HALF) >>> FRAC_BITS;
    sum    = {{(SUMW - DATA_WIDTH){act_i[DATA_WIDTH-1]}}, act_i}
           + {prod_r[PW-1], prod_r};
    sat_o  = (sum > HI) || (sum < LO);
    if (sum > HI)      sum_o = HI[DATA_WIDTH-1:0];
    else if (sum < LO) sum_o = LO[DATA_WIDTH-1:0];
    else               sum_o = sum[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/noise_injector.sv
// Streams a channel-major tensor through a one-deep output register, adding
// scaled noise read from the filler's BRAM. NOISE_INJ_SAT_CNT_EN adds sat_count.
module noise_injector
  import noise_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int SCALE_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int CHAN_WIDTH  = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             size,
  input  logic [CHAN_WIDTH-1:0]  num_ch,
  input  logic [SCALE_WIDTH-1:0] noise_scale,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  input  logic [DATA_WIDTH-1:0]  bram_rdata,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
`ifdef NOISE_INJ_SAT_CNT_EN
  output logic [15:0]            sat_count,
`endif
  output logic                   done
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pix_q, pix_d, last_pix_q, last_pix_d;
  logic [CHAN_WIDTH-1:0]  ch_q, ch_d, last_ch_q, last_ch_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic                   tail_q, tail_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;

  logic                   ready_c, accept, out_hs, beat_last, pix_wrap;
  logic [DATA_WIDTH-1:0]  mac_sum;
  logic                   mac_sat;

  noise_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .act_i  (s_data),
    .noise_i(bram_rdata),
    .scale_i(scale_q),
    .sum_o  (mac_sum),
    .sat_o  (mac_sat)
  );

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    ch_d       = ch_q;
    last_pix_d = last_pix_q;
    last_ch_d  = last_ch_q;
    scale_d    = scale_q;
    tail_d     = tail_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;

    ready_c   = (state_q == RUN) && !tail_q && (!m_valid_q || m_ready);
    accept    = s_valid && ready_c;
    out_hs    = m_valid_q && m_ready;
    pix_wrap  = (pix_q == last_pix_q);
    beat_last = pix_wrap && (ch_q == last_ch_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PREFETCH;
          last_pix_d = ADDR_WIDTH'(map_area(size) - 32'd1);
          last_ch_d  = (num_ch == '0) ? '0 : num_ch - CHAN_WIDTH'(1);
          scale_d    = noise_scale;
          pix_d      = '0;
          ch_d       = '0;
          tail_d     = 1'b0;
        end
      end
      PREFETCH: state_d = RUN;
      RUN: begin
        // Output register reloads on accept even when it drains in the same cycle.
        if (accept) begin
          pix_d     = pix_wrap ? '0 : pix_q + ADDR_WIDTH'(1);
          ch_d      = pix_wrap ? ch_q + CHAN_WIDTH'(1) : ch_q;
          tail_d    = beat_last;
          m_valid_d = 1'b1;
          m_data_d  = mac_sum;
          m_last_d  = beat_last;
        end else if (out_hs) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (out_hs && m_last_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      ch_q       <= '0;
      last_pix_q <= '0;
      last_ch_q  <= '0;
      scale_q    <= '0;
      tail_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      last_pix_q <= last_pix_d;
      last_ch_q  <= last_ch_d;
      scale_q    <= scale_d;
      tail_q     <= tail_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

  // Address is the next pixel so the 1-cycle BRAM returns the current pixel's noise.
  assign bram_addr = (state_q == RUN) ? pix_d : '0;
  assign s_ready   = ready_c;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q == PREFETCH) || (state_q == RUN);
  assign done      = (state_q == DONE);

`ifdef NOISE_INJ_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                        sat_cnt_q <= '0;
    else if (state_q == IDLE && start)              sat_cnt_q <= '0;
    else if (accept && mac_sat && sat_cnt_q != '1)  sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = mac_sat;
`endif

endmodule

// File: tb/tb_noise_injector.sv
// Scoreboard bench for noise_injector: the driver pushes expected beats, a
// negedge monitor pops and compares on every output handshake.
module tb_noise_injector;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam int SW = 16;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    size;
  logic [CW-1:0] num_ch;
  logic [SW-1:0] noise_scale;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last, busy, done;
  logic [DW-1:0] m_data;
`ifdef NOISE_INJ_SAT_CNT_EN
  logic [15:0]   sat_count;
`endif

  noise_injector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .size       (size),
    .num_ch     (num_ch),
    .noise_scale(noise_scale),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
`ifdef NOISE_INJ_SAT_CNT_EN
    .sat_count  (sat_count),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) bram_rdata <= mem[bram_addr];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_cyc = -10;
  int   done_cnt = 0;
  bit   rand_ready = 1'b0;
  bit   ready_val  = 1'b1;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] n,
                                          input logic [SW-1:0] s);
    longint p, pr, sum;
    p   = longint'($signed(n)) * longint'($signed(s));
    pr  = (p + 128) >>> 8;
    sum = longint'($signed(x)) + pr;
    if (sum > 32767)  return 16'h7FFF;
    if (sum < -32768) return 16'h8000;
    return sum[15:0];
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_d));
        check("hold_last", 32'(m_last), 32'(prev_l));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat actual=%h required=no_beat (t=%0t)", m_data, $time);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(m_data), 32'(e.d));
          check("beat_last", 32'(m_last), 32'(e.l));
        end
        if (m_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_timing", 32'(cyc), 32'(last_cyc + 1));
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  task automatic run_job(input logic [2:0] sz, input logic [CW-1:0] nch, input logic [SW-1:0] sc,
                         input logic [DW-1:0] base, input logic [DW-1:0] step,
                         input bit rnd_valid, input bit mid_start);
    int            area, nc, n, d0, pix, guard;
    logic [DW-1:0] xd;
    area = 16 << (2 * ((sz > 3'd5) ? 5 : int'(sz)));
    nc   = (nch == 0) ? 1 : int'(nch);
    n    = area * nc;
    d0   = done_cnt;
    @(posedge clk); #1;
    size = sz; num_ch = nch; noise_scale = sc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (rnd_valid) begin
        while ($urandom_range(0, 1) == 1) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      xd      = base + DW'(k) * step;
      s_valid = 1'b1;
      s_data  = xd;
      if (mid_start && k == 5) begin
        start = 1'b1; size = 3'd0; num_ch = 9'd1; noise_scale = '0;
      end
      guard = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        guard++;
        if (guard > 1000) begin
          $display("FAIL s_ready_timeout actual=0 required=1 (beat %0d)", k);
          $fatal(1, "bench stalled");
        end
      end
      pix = k % area;
      sb.push_back('{d: model(xd, mem[pix], sc), l: (k == n - 1)});
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("ready_after_last", 32'(s_ready), 32'd0);
    for (int g = 0; g < 300 && done_cnt == d0; g++) @(negedge clk);
    @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; size = '0; num_ch = '0; noise_scale = '0;
    s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < 16384; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x4, one channel, unity scale, BRAM[i]=i: out = 0x0100 + i
    run_job(3'd0, 9'd1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0);

    // 8x8 x3 channels, noise 3 * 0.5 rounds half-up to 2
    for (int i = 0; i < 64; i++) mem[i] = 16'h0003;
    run_job(3'd1, 9'd3, 16'h0080, 16'h0100, 16'h0001, 1'b0, 1'b0);

    // Saturation, positive then negative
    for (int i = 0; i < 16; i++) mem[i] = 16'h7FFF;
    run_job(3'd0, 9'd1, 16'h7FFF, 16'h7F00, 16'h0000, 1'b0, 1'b0);
`ifdef NOISE_INJ_SAT_CNT_EN
    check("sat_count_pos", 32'(sat_count), 32'd16);
`endif
    run_job(3'd0, 9'd1, 16'h8000, 16'h8100, 16'h0000, 1'b0, 1'b0);
`ifdef NOISE_INJ_SAT_CNT_EN
    check("sat_count_neg", 32'(sat_count), 32'd16);
`endif

    // Random stalls on both sides, mixed-sign noise, negative scale
    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 37 - 300);
    rand_ready = 1'b1;
    run_job(3'd2, 9'd2, 16'hFF40, 16'h1234, 16'h0111, 1'b1, 1'b0);
    rand_ready = 1'b0;

    // start pulsed while running must be ignored
    run_job(3'd1, 9'd1, 16'h0100, 16'h0000, 16'h0005, 1'b0, 1'b1);

    // Reset mid-run with a stalled output beat
    ready_val = 1'b0;
    @(posedge clk); #1;
    size = 3'd1; num_ch = 9'd1; noise_scale = 16'h0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 16'h0005;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("valid_before_rst", 32'(m_valid), 32'd1);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    ready_val = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    sb.delete();

    // Fresh job after abort
    for (int i = 0; i < 16384; i++) mem[i] = DW'(i);
    run_job(3'd0, 9'd1, 16'h0100, 16'h0020, 16'h0003, 1'b0, 1'b0);

    // size 7 clamps to 128x128, num_ch 0 means one channel
    run_job(3'd7, 9'd0, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
